mem_seq_master: RTL and testbench

Initiator for the memory valid/ready request interface: on a start command it issues a burst of write and/or read transactions over a contiguous address range, generates an incrementing data pattern, and checks read data against it. Sits between the test/control logic and the `memory` responder, driving exactly the signals the responder consumes, and replaces hand-driven stimulus for fill/verify passes.

---
 rtl/mem_pkg.sv | 34 +++
 rtl/mem_addr_gen.sv | 64 ++++++
 rtl/mem_seq_master.sv | 192 +++++++++++++++++++
 tb/tb_mem_seq_master.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory sequencing master, its address
// generator, the memory responder and the bench.
//   MEM_WIDTH / MEM_ADDR_WIDTH / MEM_DEPTH : default geometry
//   mode_t  : command mode (write-only, read-verify, write-then-verify)
//   state_t : master FSM state
package mem_pkg;

    localparam int MEM_WIDTH      = 16;
    localparam int MEM_ADDR_WIDTH = 4;
    localparam int MEM_DEPTH      = 16;

    typedef enum logic [1:0] {
        MODE_WR  = 2'b00,
        MODE_RDV = 2'b01,
        MODE_WRV = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_READ  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Raw command encoding 2'b11 behaves as write-then-verify.
    function automatic mode_t decode_mode(input logic [1:0] raw);
        case (raw)
            2'b00:   return MODE_WR;
            2'b01:   return MODE_RDV;
            default: return MODE_WRV;
        endcase
    endfunction

endpackage

// File: rtl/mem_addr_gen.sv
// Address generator for mem_seq_master.
// Holds the latched base address and clamped word count, and the word
// offset within the current phase.
//   load_i      : latch base_i / clamped count_i, offset <- 0
//   restart_i   : offset <- 0 (write -> read turnaround)
//   step_i      : offset <- offset + 1 (one handshake)
//   count_zero_o: clamped count_i is zero (combinational, for the start decision)
//   base_o      : latched base address
//   offset_o    : current word offset
//   next_addr_o : (base + offset + 1) mod 2**ADDR_WIDTH
//   last_o      : current offset is the final word of the phase
module mem_addr_gen #(
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  restart_i,
    input  logic                  step_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH:0]   count_i,
    output logic                  count_zero_o,
    output logic [ADDR_WIDTH-1:0] base_o,
    output logic [ADDR_WIDTH:0]   offset_o,
    output logic [ADDR_WIDTH-1:0] next_addr_o,
    output logic                  last_o
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH:0]   count_clamped;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   offset_q;
    logic [ADDR_WIDTH-1:0] base_q;

    assign count_clamped = (count_i > DEPTH_W) ? DEPTH_W : count_i;
    assign count_zero_o  = (count_clamped == '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            base_q   <= '0;
            count_q  <= '0;
            offset_q <= '0;
        end else if (load_i) begin
            base_q   <= base_i;
            count_q  <= count_clamped;
            offset_q <= '0;
        end else if (restart_i) begin
            offset_q <= '0;
        end else if (step_i) begin
            offset_q <= offset_q + ONE_W;
        end
    end

    assign base_o      = base_q;
    assign offset_o    = offset_q;
    // Truncation to ADDR_WIDTH bits gives the wrap past the top address.
    assign next_addr_o = base_q + offset_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
    // count_q is never zero while a phase is active, so count_q-1 is safe.
    assign last_o      = (offset_q == count_q - ONE_W);

endmodule

// File: rtl/mem_seq_master.sv
// Memory request initiator: on start_i issues a burst of writes and/or
// reads over a contiguous (wrapping) address range, writes an
// incrementing pattern seed+offset and checks read data against it.
// Ports:
//   clk_i, rst_i (async, active-low)
//   start_i, mode_i, base_addr_i, count_i, seed_i : command, sampled in IDLE only
//   addr_o, wdata_o, wr_rd_en_o, valid_o          : request to responder
//   rdata_i, ready_i                              : responder return
//   busy_o, done_o                                : command status
//   err_o, err_count_o, first_err_addr_o          : read-verify results
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | waiting for start_i
// ST_WRITE | presenting write requests, one per handshake
// ST_READ  | presenting read requests, checking rdata_i
// ST_DONE  | one-cycle completion, done_o high
module mem_seq_master
    import mem_pkg::*;
#(
    parameter int WIDTH      = MEM_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DEPTH      = MEM_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   count_i,
    input  logic [WIDTH-1:0]      seed_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      wdata_o,
    output logic                  wr_rd_en_o,
    output logic                  valid_o,
    input  logic [WIDTH-1:0]      rdata_i,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH:0]   err_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o
);

    state_t                state;
    mode_t                 mode_q;
    mode_t                 cmd_mode;
    logic [WIDTH-1:0]      seed_q;
    logic [WIDTH-1:0]      exp_data;
    logic [WIDTH-1:0]      next_wdata;

    logic                  ag_load;
    logic                  ag_restart;
    logic                  ag_step;
    logic                  count_zero;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   offset;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  last;
    logic                  handshake;

    assign cmd_mode   = decode_mode(mode_i);
    // valid_o is only ever high in WRITE/READ, so this marks a transfer.
    assign handshake  = valid_o & ready_i;
    assign ag_load    = (state == ST_IDLE) & start_i;
    assign ag_step    = handshake;
    assign ag_restart = handshake & last & (state == ST_WRITE) & (mode_q != MODE_WR);

    // Pattern word for the current offset, and for the one after it so the
    // registered wdata_o is ready on the cycle right after a handshake.
    assign exp_data   = seed_q + WIDTH'(offset);
    assign next_wdata = exp_data + WIDTH'(1);

    mem_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_addr_gen (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (ag_load),
        .restart_i    (ag_restart),
        .step_i       (ag_step),
        .base_i       (base_addr_i),
        .count_i      (count_i),
        .count_zero_o (count_zero),
        .base_o       (base_q),
        .offset_o     (offset),
        .next_addr_o  (next_addr),
        .last_o       (last)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state            <= ST_IDLE;
            mode_q           <= MODE_WR;
            seed_q           <= '0;
            addr_o           <= '0;
            wdata_o          <= '0;
            wr_rd_en_o       <= 1'b0;
            valid_o          <= 1'b0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            err_o            <= 1'b0;
            err_count_o      <= '0;
            first_err_addr_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        mode_q           <= cmd_mode;
                        seed_q           <= seed_i;
                        err_o            <= 1'b0;
                        err_count_o      <= '0;
                        first_err_addr_o <= '0;
                        busy_o           <= 1'b1;
                        if (count_zero) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end else begin
                            valid_o <= 1'b1;
                            addr_o  <= base_addr_i;
                            if (cmd_mode == MODE_RDV) begin
                                state      <= ST_READ;
                                wr_rd_en_o <= 1'b0;
                                wdata_o    <= '0;
                            end else begin
                                state      <= ST_WRITE;
                                wr_rd_en_o <= 1'b1;
                                wdata_o    <= seed_i;
                            end
                        end
                    end
                end

                ST_WRITE: begin
                    if (handshake) begin
                        if (!last) begin
                            addr_o  <= next_addr;
                            wdata_o <= next_wdata;
                        end else if (mode_q == MODE_WR) begin
                            state      <= ST_DONE;
                            done_o     <= 1'b1;
                            valid_o    <= 1'b0;
                            addr_o     <= '0;
                            wdata_o    <= '0;
                            wr_rd_en_o <= 1'b0;
                        end else begin
                            // Turnaround without a bubble: valid_o stays high.
                            state      <= ST_READ;
                            addr_o     <= base_q;
                            wdata_o    <= '0;
                            wr_rd_en_o <= 1'b0;
                        end
                    end
                end

                ST_READ: begin
                    if (handshake) begin
                        if (rdata_i != exp_data) begin
                            err_o       <= 1'b1;
                            err_count_o <= err_count_o + (ADDR_WIDTH+1)'(1);
                            if (err_count_o == '0) begin
                                first_err_addr_o <= addr_o;
                            end
                        end
                        if (!last) begin
                            addr_o <= next_addr;
                        end else begin
                            state   <= ST_DONE;
                            done_o  <= 1'b1;
                            valid_o <= 1'b0;
                            addr_o  <= '0;
                        end
                    end
                end

                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end

                default: begin
                    state   <= ST_IDLE;
                    valid_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_seq_master.sv
module tb_mem_seq_master;
    import mem_pkg::*;

    localparam int W  = MEM_WIDTH;
    localparam int AW = MEM_ADDR_WIDTH;
    localparam int D  = MEM_DEPTH;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          start_i = 1'b0;
    logic [1:0]    mode_i = 2'b00;
    logic [AW-1:0] base_addr_i = '0;
    logic [AW:0]   count_i = '0;
    logic [W-1:0]  seed_i = '0;
    logic [AW-1:0] addr_o;
    logic [W-1:0]  wdata_o;
    logic          wr_rd_en_o;
    logic          valid_o;
    logic [W-1:0]  rdata_i;
    logic          ready_i = 1'b1;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [AW:0]   err_count_o;
    logic [AW-1:0] first_err_addr_o;

    mem_seq_master dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .mode_i           (mode_i),
        .base_addr_i      (base_addr_i),
        .count_i          (count_i),
        .seed_i           (seed_i),
        .addr_o           (addr_o),
        .wdata_o          (wdata_o),
        .wr_rd_en_o       (wr_rd_en_o),
        .valid_o          (valid_o),
        .rdata_i          (rdata_i),
        .ready_i          (ready_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o),
        .err_count_o      (err_count_o),
        .first_err_addr_o (first_err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } txn_t;

    txn_t         exp_q[$];
    logic [W-1:0] mem [D];
    int           checks = 0;
    int           failures = 0;
    int           hs_cmd = 0;
    int           exp_errs = 0;
    int           exp_first = 0;
    bit           active = 1'b0;
    bit           ready_rand = 1'b0;
    int           lat;

    assign rdata_i = mem[addr_o];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Whole-command model: expected request sequence plus the error result,
    // derived from the command fields and a shadow of current memory.
    task automatic build_model(input logic [1:0] md, input int base, input int cnt, input int seed);
        logic [W-1:0] shadow [D];
        int   n;
        int   m;
        txn_t t;
        exp_q.delete();
        exp_errs  = 0;
        exp_first = 0;
        n = (cnt > D) ? D : cnt;
        m = (md == 2'b11) ? 2 : int'(md);
        for (int i = 0; i < D; i++) shadow[i] = mem[i];
        if (m != 1) begin
            for (int k = 0; k < n; k++) begin
                t.wr   = 1'b1;
                t.addr = AW'((base + k) % (1 << AW));
                t.data = W'(seed + k);
                shadow[t.addr] = t.data;
                exp_q.push_back(t);
            end
        end
        if (m != 0) begin
            for (int k = 0; k < n; k++) begin
                t.wr   = 1'b0;
                t.addr = AW'((base + k) % (1 << AW));
                t.data = '0;
                if (shadow[t.addr] != W'(seed + k)) begin
                    exp_errs++;
                    if (exp_errs == 1) exp_first = int'(t.addr);
                end
                exp_q.push_back(t);
            end
        end
    endtask

    task automatic issue(input logic [1:0] md, input int base, input int cnt, input int seed);
        @(negedge clk_i);
        mode_i      = md;
        base_addr_i = AW'(base);
        count_i     = (AW+1)'(cnt);
        seed_i      = W'(seed);
        start_i     = 1'b1;
        build_model(md, base, cnt, seed);
        @(posedge clk_i);
        hs_cmd = 0;
        active = 1'b1;
        #1 start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int l);
        l = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk_i);
            if (done_o) begin
                l = k;
                break;
            end
        end
        if (l < 0) begin
            chk("done_timeout", 32'd0, 32'd1);
            active = 1'b0;
            exp_q.delete();
        end
        @(negedge clk_i);
        chk("busy_after_done", 32'(busy_o), 32'd0);
    endtask

    task automatic chk_err_model();
        chk("err_o", 32'(err_o), 32'(exp_errs != 0));
        chk("err_count", 32'(err_count_o), 32'(exp_errs));
        chk("first_err_addr", 32'(first_err_addr_o), 32'(exp_first));
    endtask

    always @(negedge clk_i) begin
        ready_i = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare: while a command is active the DUT must present the head of
    // the expected queue, and signal done exactly when the queue is drained.
    always @(negedge clk_i) begin
        if (active) begin
            chk("valid", 32'(valid_o), 32'(exp_q.size() != 0));
            if (valid_o && exp_q.size() != 0) begin
                chk("wr_rd_en", 32'(wr_rd_en_o), 32'(exp_q[0].wr));
                chk("addr", 32'(addr_o), 32'(exp_q[0].addr));
                chk("wdata", 32'(wdata_o), 32'(exp_q[0].data));
            end
            chk("busy", 32'(busy_o), 32'd1);
            chk("done", 32'(done_o), 32'(exp_q.size() == 0));
            if (done_o) active = 1'b0;
        end else if (rst_i) begin
            chk("idle_valid", 32'(valid_o), 32'd0);
            chk("idle_busy", 32'(busy_o), 32'd0);
            chk("idle_done", 32'(done_o), 32'd0);
        end
    end

    // Responder and handshake accounting.
    always @(posedge clk_i) begin
        if (rst_i && valid_o && ready_i) begin
            hs_cmd++;
            chk("hs_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (wr_rd_en_o) mem[addr_o] = wdata_o;
        end
    end

    initial begin
        for (int i = 0; i < D; i++) mem[i] = 16'hF000 | W'(i);

        // Reset state
        #12;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_err_count", 32'(err_count_o), 32'd0);
        chk("rst_first", 32'(first_err_addr_o), 32'd0);
        chk("rst_addr", 32'(addr_o), 32'd0);
        chk("rst_wdata", 32'(wdata_o), 32'd0);
        chk("rst_wr", 32'(wr_rd_en_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Write-then-verify full memory
        issue(2'b10, 0, 16, 16'h00A0);
        wait_done(100, lat);
        chk("t1_latency", 32'(lat), 32'd32);
        chk("t1_handshakes", 32'(hs_cmd), 32'd32);
        chk_err_model();
        chk("t1_err_count_lit", 32'(err_count_o), 32'd0);
        chk("t1_mem15_lit", 32'(mem[15]), 32'h00AF);

        // Read-verify with a planted mismatch
        mem[4] = 16'd5;
        mem[5] = 16'd6;
        mem[6] = 16'd9;
        issue(2'b01, 4, 3, 5);
        wait_done(50, lat);
        chk("t2_latency", 32'(lat), 32'd3);
        chk_err_model();
        chk("t2_err_count_lit", 32'(err_count_o), 32'd1);
        chk("t2_first_lit", 32'(first_err_addr_o), 32'd6);
        chk("t2_err_lit", 32'(err_o), 32'd1);

        // Write-only across the address wrap, then read it back
        issue(2'b00, 14, 4, 16'h1230);
        wait_done(50, lat);
        chk("t3_latency", 32'(lat), 32'd4);
        chk("t3_mem14", 32'(mem[14]), 32'h1230);
        chk("t3_mem15", 32'(mem[15]), 32'h1231);
        chk("t3_mem0", 32'(mem[0]), 32'h1232);
        chk("t3_mem1", 32'(mem[1]), 32'h1233);
        issue(2'b01, 14, 4, 16'h1230);
        wait_done(50, lat);
        chk_err_model();
        chk("t3_readback_err_lit", 32'(err_count_o), 32'd0);

        // Stalling responder, mode 11 behaves as write-then-verify
        ready_rand = 1'b1;
        issue(2'b11, 3, 10, 16'hBEEF);
        wait_done(800, lat);
        chk("t4_handshakes", 32'(hs_cmd), 32'd20);
        chk_err_model();
        ready_rand = 1'b0;

        // count 0 and clamp of 20 to DEPTH
        issue(2'b10, 7, 0, 16'h0001);
        wait_done(20, lat);
        chk("t5_zero_latency", 32'(lat), 32'd0);
        chk("t5_zero_handshakes", 32'(hs_cmd), 32'd0);
        issue(2'b00, 5, 20, 16'h0007);
        wait_done(100, lat);
        chk("t5_clamp_handshakes", 32'(hs_cmd), 32'd16);
        chk("t5_clamp_latency", 32'(lat), 32'd16);

        // start pulse during a burst is ignored
        issue(2'b10, 2, 6, 16'h1234);
        repeat (3) @(negedge clk_i);
        mode_i      = 2'b00;
        base_addr_i = AW'(9);
        count_i     = (AW+1)'(1);
        seed_i      = 16'hDEAD;
        start_i     = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done(100, lat);
        chk("t6_handshakes", 32'(hs_cmd), 32'd12);
        chk_err_model();

        // Reset during the 5th write of 16
        issue(2'b00, 0, 16, 16'h5000);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (hs_cmd == 4) break;
        end
        chk("t7_reach_5th", 32'(hs_cmd), 32'd4);
        #2;
        active = 1'b0;
        exp_q.delete();
        rst_i = 1'b0;
        #1;
        chk("t7_rst_valid", 32'(valid_o), 32'd0);
        chk("t7_rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        chk("t7_no_5th_write", 32'(mem[4]), 32'h1236);
        chk("t7_4th_write", 32'(mem[3]), 32'h5003);
        issue(2'b10, 8, 5, 16'h0042);
        wait_done(100, lat);
        chk("t7_after_latency", 32'(lat), 32'd10);
        chk("t7_after_handshakes", 32'(hs_cmd), 32'd10);
        chk_err_model();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
